// File: rtl/alu_op_sequencer_pkg.sv
// Shared opcode constants, sequencer state encoding and default widths
// used by both the ALU and the sequencer.
package alu_op_sequencer_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 32;
    localparam int OP_W       = 5;

    typedef enum logic [OP_W-1:0] {
        A_NOP = 5'd0,
        A_ADD = 5'd1,
        A_SUB = 5'd2,
        A_AND = 5'd3,
        A_OR  = 5'd4,
        A_XOR = 5'd5,
        A_NOR = 5'd6
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } seq_state_e;

    // Only real arithmetic/logic ops produce a RAM write; NOP and unknown codes do not.
    function automatic logic op_writes(input logic [OP_W-1:0] op);
        return (op >= A_ADD) && (op <= A_NOR);
    endfunction

    function automatic logic op_illegal(input logic [OP_W-1:0] op);
        return op > A_NOR;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command, dual-port RAM, external ALU and status signals of the sequencer.
// master = sequencer side, slave = surrounding RAM/ALU/command source.
interface alu_op_sequencer_if #(
    parameter int ADDR_W = alu_op_sequencer_pkg::DEF_ADDR_W,
    parameter int DATA_W = alu_op_sequencer_pkg::DEF_DATA_W
);
    import alu_op_sequencer_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [ADDR_W-1:0] cmd_src_a;
    logic [ADDR_W-1:0] cmd_src_b;
    logic [ADDR_W-1:0] cmd_dst;

    logic [ADDR_W-1:0] ram_addr_a;
    logic [ADDR_W-1:0] ram_addr_b;
    logic [DATA_W-1:0] ram_dout_a;
    logic [DATA_W-1:0] ram_dout_b;
    logic              ram_we;
    logic [DATA_W-1:0] ram_din;

    logic [DATA_W-1:0] ALU_A;
    logic [DATA_W-1:0] ALU_B;
    logic [OP_W-1:0]   ALU_OP;
    logic [DATA_W-1:0] ALU_OUT;

    logic              done;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              err_op;

    modport master (
        input  cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst,
        input  ram_dout_a, ram_dout_b, ALU_OUT,
        output cmd_ready, ram_addr_a, ram_addr_b, ram_we, ram_din,
        output ALU_A, ALU_B, ALU_OP, done, result, zero, err_op
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst,
        output ram_dout_a, ram_dout_b, ALU_OUT,
        input  cmd_ready, ram_addr_a, ram_addr_b, ram_we, ram_din,
        input  ALU_A, ALU_B, ALU_OP, done, result, zero, err_op
    );

endinterface

// File: rtl/alu_op_sequencer_alu.sv
// Combinational ALU placed beside the sequencer at the parent level.
// Unknown opcodes and NOP yield zero; arithmetic wraps at DATA_W bits.
module alu_op_sequencer_alu #(
    parameter int DATA_W = alu_op_sequencer_pkg::DEF_DATA_W
) (
    input  logic [DATA_W-1:0]                     a,
    input  logic [DATA_W-1:0]                     b,
    input  logic [alu_op_sequencer_pkg::OP_W-1:0] op,
    output logic [DATA_W-1:0]                     y
);
    import alu_op_sequencer_pkg::*;

    always_comb begin
        y = '0;
        case (op)
            A_ADD:   y = a + b;
            A_SUB:   y = a - b;
            A_AND:   y = a & b;
            A_OR:    y = a | b;
            A_XOR:   y = a ^ b;
            A_NOR:   y = ~(a | b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Purpose: reads two RAM operands, runs them through an external ALU, writes the result back.
// Latency: done pulses 4 cycles after the accepting handshake; one command per 5 cycles.
// Backpressure: cmd_ready is high only in IDLE; command inputs are ignored in every other state.
module alu_op_sequencer #(
    parameter int ADDR_W = alu_op_sequencer_pkg::DEF_ADDR_W,
    parameter int DATA_W = alu_op_sequencer_pkg::DEF_DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    alu_op_sequencer_if.master bus
);
    import alu_op_sequencer_pkg::*;

    seq_state_e        state_q;
    seq_state_e        state_d;
    logic [OP_W-1:0]   op_q;
    logic [ADDR_W-1:0] src_a_q;
    logic [ADDR_W-1:0] src_b_q;
    logic [ADDR_W-1:0] dst_q;
    logic [DATA_W-1:0] result_q;
    logic              zero_q;
    logic              accept;

    assign accept = (state_q == S_IDLE) && bus.cmd_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
            dst_q   <= '0;
        end else if (accept) begin
            op_q    <= bus.cmd_op;
            src_a_q <= bus.cmd_src_a;
            src_b_q <= bus.cmd_src_b;
            dst_q   <= bus.cmd_dst;
        end
    end

    // NOP and illegal opcodes force a zero result regardless of what the ALU returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b0;
        end else if (state_q == S_EXEC) begin
            if (op_writes(op_q)) begin
                result_q <= bus.ALU_OUT;
                zero_q   <= (bus.ALU_OUT == '0);
            end else begin
                result_q <= '0;
                zero_q   <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        bus.cmd_ready  = 1'b0;
        bus.ram_addr_a = '0;
        bus.ram_addr_b = '0;
        bus.ram_we     = 1'b0;
        bus.ram_din    = '0;
        bus.ALU_A      = '0;
        bus.ALU_B      = '0;
        bus.ALU_OP     = A_NOP;
        bus.done       = 1'b0;
        bus.err_op     = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                bus.ram_addr_a = src_a_q;
                bus.ram_addr_b = src_b_q;
                state_d        = S_EXEC;
            end
            S_EXEC: begin
                bus.ALU_A  = bus.ram_dout_a;
                bus.ALU_B  = bus.ram_dout_b;
                bus.ALU_OP = op_q;
                state_d    = S_WRITE;
            end
            S_WRITE: begin
                bus.ram_addr_a = dst_q;
                bus.ram_we     = op_writes(op_q);
                bus.ram_din    = result_q;
                state_d        = S_DONE;
            end
            S_DONE: begin
                bus.done   = 1'b1;
                bus.err_op = op_illegal(op_q);
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.result = result_q;
    assign bus.zero   = zero_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: RAM and ALU beside the sequencer, a command-level model predicting
// every output each cycle, and literal expectations for the headline scenarios.
module tb_alu_op_sequencer;
    import alu_op_sequencer_pkg::*;

    localparam int AW = 6;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_op_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    alu_op_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    alu_op_sequencer_alu #(.DATA_W(DW)) u_alu (
        .a  (bus.ALU_A),
        .b  (bus.ALU_B),
        .op (bus.ALU_OP),
        .y  (bus.ALU_OUT)
    );

    // Dual-port RAM with registered reads; the bench preloads through its own write path.
    logic [DW-1:0] ram [64];
    logic          tb_we;
    logic [AW-1:0] tb_addr;
    logic [DW-1:0] tb_din;

    always @(posedge clk) begin
        if (tb_we) ram[tb_addr] <= tb_din;
        else if (bus.ram_we) ram[bus.ram_addr_a] <= bus.ram_din;
        bus.ram_dout_a <= ram[bus.ram_addr_a];
        bus.ram_dout_b <= ram[bus.ram_addr_b];
    end

    // Command-level model: phase counts cycles since acceptance (0 = idle).
    logic [DW-1:0] mdl_mem [64];
    int            phase  = 0;
    logic [4:0]    m_op   = '0;
    logic [AW-1:0] m_a    = '0;
    logic [AW-1:0] m_b    = '0;
    logic [AW-1:0] m_dst  = '0;
    logic [DW-1:0] m_va   = '0;
    logic [DW-1:0] m_vb   = '0;
    logic [DW-1:0] p_res  = '0;
    logic          p_we   = 1'b0;
    logic          p_err  = 1'b0;
    logic [DW-1:0] m_res  = '0;
    logic          m_zero = 1'b0;

    function automatic logic [DW-1:0] model_alu(input logic [4:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            5'd1:    return a + b;
            5'd2:    return a - b;
            5'd3:    return a & b;
            5'd4:    return a | b;
            5'd5:    return a ^ b;
            5'd6:    return ~(a | b);
            default: return '0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (tb_we) mdl_mem[tb_addr] = tb_din;
        if (rst) begin
            phase  = 0;
            m_res  = '0;
            m_zero = 1'b0;
        end else if (phase != 0) begin
            phase = phase + 1;
            if (phase == 3) begin
                m_res  = p_res;
                m_zero = (p_res == '0);
            end
            if (phase == 4 && p_we) mdl_mem[m_dst] = p_res;
            if (phase == 5) phase = 0;
        end else if (bus.cmd_valid) begin
            m_op  = bus.cmd_op;
            m_a   = bus.cmd_src_a;
            m_b   = bus.cmd_src_b;
            m_dst = bus.cmd_dst;
            m_va  = mdl_mem[m_a];
            m_vb  = mdl_mem[m_b];
            p_we  = (m_op >= 5'd1) && (m_op <= 5'd6);
            p_err = m_op > 5'd6;
            p_res = model_alu(m_op, m_va, m_vb);
            phase = 1;
        end
    end

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            chk("cmd_ready", bus.cmd_ready, phase == 0);
            chk("done", bus.done, phase == 4);
            chk("err_op", bus.err_op, (phase == 4) && p_err);
            chk("ram_we", bus.ram_we, (phase == 3) && p_we);
            chk("result", bus.result, m_res);
            chk("zero", bus.zero, m_zero);
            if (phase == 1) begin
                chk("rd_addr_a", bus.ram_addr_a, m_a);
                chk("rd_addr_b", bus.ram_addr_b, m_b);
            end
            if (phase == 2) begin
                chk("alu_a", bus.ALU_A, m_va);
                chk("alu_b", bus.ALU_B, m_vb);
                chk("alu_op", bus.ALU_OP, m_op);
            end else begin
                chk("alu_a_idle", bus.ALU_A, 0);
                chk("alu_b_idle", bus.ALU_B, 0);
                chk("alu_op_idle", bus.ALU_OP, 0);
            end
            if (phase == 3) begin
                chk("wr_addr", bus.ram_addr_a, m_dst);
                chk("wr_data", bus.ram_din, m_res);
            end
        end
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] v);
        tb_we   = 1'b1;
        tb_addr = a;
        tb_din  = v;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.cmd_ready) timeout("ready_wait");
    endtask

    // junk=1 keeps cmd_valid high with a different command for the whole busy period.
    task automatic run_cmd(input logic [4:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input logic [AW-1:0] d, input bit junk,
                           output logic [DW-1:0] r, output logic z, output logic e, output int lat);
        wait_ready();
        bus.cmd_op    = op;
        bus.cmd_src_a = a;
        bus.cmd_src_b = b;
        bus.cmd_dst   = d;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        if (junk) begin
            bus.cmd_op    = 5'd2;
            bus.cmd_src_a = 6'd7;
            bus.cmd_src_b = 6'd1;
            bus.cmd_dst   = 6'd1;
        end else begin
            bus.cmd_valid = 1'b0;
        end
        while (!bus.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        bus.cmd_valid = 1'b0;
        if (!bus.done) timeout("done_wait");
        r = bus.result;
        z = bus.zero;
        e = bus.err_op;
    endtask

    logic [DW-1:0] r;
    logic          z;
    logic          e;
    int            lat;
    time           t0;
    logic [DW-1:0] lop_exp [4];

    initial begin
        rst           = 1'b0;
        tb_we         = 1'b0;
        tb_addr       = '0;
        tb_din        = '0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_src_a = '0;
        bus.cmd_src_b = '0;
        bus.cmd_dst   = '0;
        fork
            compare_loop();
        join_none
        #1 rst = 1'b1;
        #1;
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_done", bus.done, 0);
        chk("rst_ram_we", bus.ram_we, 0);
        chk("rst_err_op", bus.err_op, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_zero", bus.zero, 0);
        chk("rst_addr_a", bus.ram_addr_a, 0);

        for (int i = 0; i < 64; i++) poke(i[AW-1:0], '0);
        poke(6'd1, 32'd5);
        poke(6'd2, 32'd3);
        poke(6'd6, 32'hFFFF_FFFF);
        poke(6'd7, 32'd1);
        poke(6'd9, 32'hABCD);
        poke(6'd10, 32'h1234);
        poke(6'd16, 32'h77);
        rst = 1'b0;
        @(posedge clk); #1;

        // ADD 5+3 -> 8
        run_cmd(A_ADD, 6'd1, 6'd2, 6'd3, 1'b0, r, z, e, lat);
        chk("add_latency", lat, 4);
        chk("add_result", r, 32'd8);
        chk("add_zero", z, 0);
        chk("add_err", e, 0);

        // SUB 5-5 -> 0, then back-to-back ADD reading the freshly written word
        wait_ready();
        poke(6'd2, 32'd5);
        run_cmd(A_SUB, 6'd1, 6'd2, 6'd4, 1'b0, r, z, e, lat);
        t0 = $time;
        chk("sub_result", r, 32'd0);
        chk("sub_zero", z, 1);
        run_cmd(A_ADD, 6'd4, 6'd1, 6'd5, 1'b0, r, z, e, lat);
        chk("b2b_spacing", ($time - t0) / 10, 5);
        chk("b2b_result", r, 32'd5);

        // Wraparound with dst equal to a source
        run_cmd(A_ADD, 6'd6, 6'd7, 6'd6, 1'b0, r, z, e, lat);
        chk("wrap_result", r, 32'd0);
        chk("wrap_zero", z, 1);

        // Illegal opcode and NOP: complete without writing
        run_cmd(5'h1F, 6'd1, 6'd2, 6'd9, 1'b0, r, z, e, lat);
        chk("illegal_err", e, 1);
        chk("illegal_result", r, 32'd0);
        chk("illegal_zero", z, 1);
        run_cmd(A_NOP, 6'd1, 6'd2, 6'd10, 1'b0, r, z, e, lat);
        chk("nop_err", e, 0);
        chk("nop_result", r, 32'd0);
        chk("nop_zero", z, 1);

        // Logic ops on 5 and 1
        lop_exp[0] = 32'd1;
        lop_exp[1] = 32'd5;
        lop_exp[2] = 32'd4;
        lop_exp[3] = 32'hFFFF_FFFA;
        for (int k = 0; k < 4; k++) begin
            run_cmd(5'(3 + k), 6'd1, 6'd7, 6'(11 + k), 1'b0, r, z, e, lat);
            chk("logic_result", r, lop_exp[k]);
        end

        // New command values held during the busy period are ignored
        run_cmd(A_ADD, 6'd1, 6'd7, 6'd15, 1'b1, r, z, e, lat);
        chk("ignore_result", r, 32'd6);

        // Reset during EXEC aborts the command immediately
        wait_ready();
        bus.cmd_op    = A_ADD;
        bus.cmd_src_a = 6'd1;
        bus.cmd_src_b = 6'd7;
        bus.cmd_dst   = 6'd16;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("abort_cmd_ready", bus.cmd_ready, 1);
        chk("abort_result", bus.result, 0);
        chk("abort_zero", bus.zero, 0);
        chk("abort_ram_we", bus.ram_we, 0);
        chk("abort_alu_op", bus.ALU_OP, 0);
        chk("abort_done", bus.done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_cmd(A_ADD, 6'd1, 6'd7, 6'd17, 1'b0, r, z, e, lat);
        chk("post_rst_latency", lat, 4);
        chk("post_rst_result", r, 32'd6);

        // Withdrawn offer with no clock edge while valid
        wait_ready();
        bus.cmd_op    = A_ADD;
        bus.cmd_dst   = 6'd20;
        bus.cmd_valid = 1'b1;
        #3 bus.cmd_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("withdraw_ready", bus.cmd_ready, 1);

        chk("ram3", ram[3], 32'd8);
        chk("ram4", ram[4], 32'd0);
        chk("ram5", ram[5], 32'd5);
        chk("ram6", ram[6], 32'd0);
        chk("ram9", ram[9], 32'hABCD);
        chk("ram10", ram[10], 32'h1234);
        chk("ram1", ram[1], 32'd5);
        chk("ram14", ram[14], 32'hFFFF_FFFA);
        chk("ram15", ram[15], 32'd6);
        chk("ram16", ram[16], 32'h77);
        chk("ram17", ram[17], 32'd6);
        for (int i = 0; i < 64; i++) chk("ram_vs_model", ram[i], mdl_mem[i]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, meaning dual-port RAM word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning operand/result width.
REQ-003 Port: clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-high.
REQ-005 Port: cmd_valid  in  1  command offered.
REQ-006 Port: cmd_ready  out  1  block can accept a command.
REQ-007 Port: cmd_op  in  5  ALU opcode (NOP=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, NOR=6).
REQ-008 Ports: cmd_src_a, cmd_src_b, cmd_dst  in  ADDR_W  operand A, operand B and destination RAM addresses.
REQ-009 Ports: ram_addr_a, ram_addr_b  out  ADDR_W  RAM port A / port B addresses.
REQ-010 Ports: ram_dout_a, ram_dout_b  in  DATA_W  RAM read data, valid one cycle after address.
REQ-011 Ports: ram_we  out  1, ram_din  out  DATA_W  write strobe and data on port A.
REQ-012 Ports: ALU_A, ALU_B  out  DATA_W; ALU_OP  out  5; ALU_OUT  in  DATA_W  external combinational ALU.
REQ-013 Ports: done  out  1  one-cycle completion pulse; result  out  DATA_W; zero  out  1; err_op  out  1.

Function
REQ-014 States SHALL be IDLE, READ, EXEC, WRITE, DONE; cmd_ready = 1 only in IDLE.
REQ-015 IDLE: cmd_valid & cmd_ready SHALL latch op/src_a/src_b/dst and go to READ; otherwise stay.
REQ-016 READ: ram_addr_a = src_a, ram_addr_b = src_b; next state EXEC.
REQ-017 EXEC: ALU_A = ram_dout_a, ALU_B = ram_dout_b, ALU_OP = latched op; result <= ALU_OUT, zero <= (ALU_OUT == 0) at end of cycle; next WRITE.
REQ-018 Outside EXEC, ALU_A = 0, ALU_B = 0, ALU_OP = 0 (NOP).
REQ-019 WRITE: ram_we = 1, ram_addr_a = dst, ram_din = result, for exactly one cycle; next DONE.
REQ-020 DONE: done = 1 for one cycle; next IDLE; result/zero hold until next EXEC.
REQ-021 Handshake-to-done latency SHALL be 4 cycles; back-to-back throughput one command per 5 cycles.
REQ-022 Op 0 (NOP) SHALL complete normally with result 0, zero 1, and ram_we held 0 in WRITE.
REQ-023 Op > 6 SHALL set err_op = 1 in DONE (with done), ram_we = 0, result 0, zero 1; err_op = 0 otherwise.
REQ-024 dst equal to a src SHALL be legal; the write completes before any later command's READ, so a following command reads the new value.
REQ-025 cmd_valid may be withdrawn before acceptance; inputs other than in IDLE SHALL be ignored.
REQ-026 Arithmetic wraps modulo 2^DATA_W; no overflow flag.

Reset
REQ-027 rst SHALL asynchronously force IDLE, cmd_ready 1, ram_we 0, done 0, err_op 0, result 0, zero 0, all address/ALU outputs 0.
REQ-028 rst asserted mid-command SHALL abort it with no RAM write and no done pulse.

Structure
REQ-029 Opcode constants (A_NOP..A_NOR), state encoding and DATA_W/ADDR_W defaults SHALL live in a shared package used by both ALU and sequencer.
REQ-030 No sub-module; the ALU and dual-port RAM SHALL be instantiated beside it at the parent level.

Verification
REQ-031 RAM[1]=5, RAM[2]=3, cmd ADD src 1,2 dst 3 -> done at T+4, result 8, zero 0, RAM[3]=8.
REQ-032 RAM[1]=5, RAM[2]=5, SUB dst 4 -> result 0, zero 1, RAM[4]=0; then ADD src 4,1 dst 5 back-to-back -> RAM[5]=5.
REQ-033 RAM[6]=32'hFFFFFFFF, RAM[7]=1, ADD dst 6 -> RAM[6]=0 (wrap), zero 1.
REQ-034 cmd_op=5'h1F -> done with err_op 1, ram_we never high; cmd_op=0 -> done, result 0, no write.
REQ-035 rst pulsed during EXEC -> outputs at reset values immediately, RAM[dst] unchanged, no done; next command completes normally.
REQ-036 cmd_valid held with new values during READ..DONE -> ignored; only IDLE-accepted command executes.
